// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch time-keeping core.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_LAP   = 2'd2,
    ST_PAUSE = 2'd3
  } sw_state_t;

  localparam int MOD_TENTHS   = 10;
  localparam int MOD_SEC_ONES = 10;
  localparam int MOD_SEC_TENS = 6;
  localparam int MOD_MIN_ONES = 10;
  localparam int MOD_MIN_TENS = 6;

  // Digits ordered MM:SS.t, most significant first
  typedef struct packed {
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic [3:0] tenths;
  } sw_time_t;

  localparam sw_time_t SAT_TIME = '{
    min_tens: 4'd5, min_ones: 4'd9, sec_tens: 4'd5, sec_ones: 4'd9, tenths: 4'd9
  };

endpackage

// File: rtl/stopwatch_if.sv
// Control inputs and display outputs of the stopwatch core, with the live FSM state for observation.
interface stopwatch_if;
  import stopwatch_pkg::*;

  // start_stop/lap/clear are single-cycle pulses with no back-pressure: each
  // pulse is acted on in the cycle it is high or dropped if illegal there.
  logic       tick_in;
  logic       start_stop;
  logic       lap;
  logic       clear;
  logic [3:0] d_tenths;
  logic [3:0] d_sec_ones;
  logic [3:0] d_sec_tens;
  logic [3:0] d_min_ones;
  logic [3:0] d_min_tens;
  logic       running;
  logic       frozen;
  logic       overflow;
  sw_state_t  state;

  modport master (
    output tick_in, start_stop, lap, clear,
    input  d_tenths, d_sec_ones, d_sec_tens, d_min_ones, d_min_tens,
    input  running, frozen, overflow, state
  );

  modport slave (
    input  tick_in, start_stop, lap, clear,
    output d_tenths, d_sec_ones, d_sec_tens, d_min_ones, d_min_tens,
    output running, frozen, overflow, state
  );

endinterface

// File: rtl/stopwatch_bcd_digit.sv
// One BCD counter digit with configurable modulus; carry is asserted when an increment wraps it.
module bcd_digit #(
  parameter int MODULUS = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       clr,
  output logic [3:0] q,
  output logic       carry
);

  localparam logic [3:0] LAST = 4'(MODULUS - 1);

  logic [3:0] r_q;

  assign q     = r_q;
  assign carry = inc & (r_q == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_q <= 4'd0;
    else if (clr)   r_q <= 4'd0;
    else if (inc)   r_q <= carry ? 4'd0 : r_q + 4'd1;
  end

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch core: tick edge detect, saturating MM:SS.t BCD chain, lap snapshot and start/stop/lap/clear FSM.
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter bit TICK_EDGE_RISING = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  stopwatch_if.slave  sw
);

  logic      r_tick_q;
  logic      w_tick_pulse;
  sw_state_t r_state, w_next;
  sw_time_t  w_count, r_lap, w_disp;
  logic      r_overflow;
  logic      w_counting, w_at_sat, w_sat_hit, w_inc;
  logic      w_snap, w_clr_all, w_set_ovf;
  logic [4:0] w_carry;

  // Reset to the idle level of the selected edge so a held tick never counts after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_tick_q <= TICK_EDGE_RISING;
    else     r_tick_q <= sw.tick_in;
  end

  assign w_tick_pulse = TICK_EDGE_RISING ? (sw.tick_in & ~r_tick_q) : (~sw.tick_in & r_tick_q);
  assign w_counting   = (r_state == ST_RUN) || (r_state == ST_LAP);
  assign w_at_sat     = (w_count == SAT_TIME);
  assign w_sat_hit    = w_counting & w_tick_pulse & w_at_sat;
  assign w_inc        = w_counting & w_tick_pulse & ~w_at_sat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_snap    = 1'b0;
    w_clr_all = 1'b0;
    w_set_ovf = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (sw.start_stop) w_next = ST_RUN;
      end
      ST_RUN: begin
        if (w_sat_hit) begin
          w_next    = ST_PAUSE;
          w_set_ovf = 1'b1;
        end else if (sw.start_stop) begin
          w_next = ST_PAUSE;
        end else if (sw.lap) begin
          w_next = ST_LAP;
          w_snap = 1'b1;
        end
      end
      ST_LAP: begin
        if (w_sat_hit) begin
          w_next    = ST_PAUSE;
          w_set_ovf = 1'b1;
        end else if (sw.start_stop) begin
          w_next = ST_PAUSE;
        end else if (sw.lap) begin
          w_next = ST_RUN;
        end
      end
      ST_PAUSE: begin
        if (sw.clear) begin
          w_next    = ST_IDLE;
          w_clr_all = 1'b1;
        end else if (sw.start_stop && !r_overflow) begin
          w_next = ST_RUN;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  bcd_digit #(.MODULUS(MOD_TENTHS)) u_tenths (
    .clk(clk), .rst(rst), .inc(w_inc), .clr(w_clr_all),
    .q(w_count.tenths), .carry(w_carry[0])
  );
  bcd_digit #(.MODULUS(MOD_SEC_ONES)) u_sec_ones (
    .clk(clk), .rst(rst), .inc(w_carry[0]), .clr(w_clr_all),
    .q(w_count.sec_ones), .carry(w_carry[1])
  );
  bcd_digit #(.MODULUS(MOD_SEC_TENS)) u_sec_tens (
    .clk(clk), .rst(rst), .inc(w_carry[1]), .clr(w_clr_all),
    .q(w_count.sec_tens), .carry(w_carry[2])
  );
  bcd_digit #(.MODULUS(MOD_MIN_ONES)) u_min_ones (
    .clk(clk), .rst(rst), .inc(w_carry[2]), .clr(w_clr_all),
    .q(w_count.min_ones), .carry(w_carry[3])
  );
  bcd_digit #(.MODULUS(MOD_MIN_TENS)) u_min_tens (
    .clk(clk), .rst(rst), .inc(w_carry[3]), .clr(w_clr_all),
    .q(w_count.min_tens), .carry(w_carry[4])
  );

  // Snapshot takes the pre-increment count, since w_count is the register output
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_lap <= '0;
    else if (w_clr_all) r_lap <= '0;
    else if (w_snap)    r_lap <= w_count;
  end

  // Top-digit carry cannot fire while saturation gates the chain; kept as a safeguard
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         r_overflow <= 1'b0;
    else if (w_clr_all)              r_overflow <= 1'b0;
    else if (w_set_ovf | w_carry[4]) r_overflow <= 1'b1;
  end

  assign w_disp        = (r_state == ST_LAP) ? r_lap : w_count;
  assign sw.d_tenths   = w_disp.tenths;
  assign sw.d_sec_ones = w_disp.sec_ones;
  assign sw.d_sec_tens = w_disp.sec_tens;
  assign sw.d_min_ones = w_disp.min_ones;
  assign sw.d_min_tens = w_disp.min_tens;
  assign sw.running    = w_counting;
  assign sw.frozen     = (r_state == ST_LAP);
  assign sw.overflow   = r_overflow;
  assign sw.state      = r_state;

endmodule

// File: tb/tb_stopwatch_core.sv
// Bench for stopwatch_core: directed scenarios plus randomized pulses against a tenths-count reference model.
module tb_stopwatch_core;
  import stopwatch_pkg::*;

  localparam int W     = 25;
  localparam int MAX_T = 35999;
  localparam int M_IDLE = 0, M_RUN = 1, M_LAP = 2, M_PAUSE = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stopwatch_if sw_if();

  stopwatch_core #(.TICK_EDGE_RISING(1'b1)) dut (
    .clk(clk),
    .rst(rst),
    .sw (sw_if)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];

  // Reference model: elapsed time as a plain count of tenths
  int m_total, m_lap, m_state;
  bit m_ovf, m_tick_prev;

  function automatic void model_reset();
    m_total = 0; m_lap = 0; m_state = M_IDLE; m_ovf = 1'b0; m_tick_prev = 1'b1;
  endfunction

  function automatic void model_step(bit t, bit ss, bit lp, bit cl);
    bit pulse, counting, sat;
    int pre;
    pulse       = t & ~m_tick_prev;
    m_tick_prev = t;
    counting    = (m_state == M_RUN) || (m_state == M_LAP);
    pre         = m_total;
    sat         = counting && pulse && (m_total == MAX_T);
    if (counting && pulse && !sat) m_total = m_total + 1;
    case (m_state)
      M_IDLE:  if (ss) m_state = M_RUN;
      M_RUN: begin
        if (sat)     begin m_state = M_PAUSE; m_ovf = 1'b1; end
        else if (ss) m_state = M_PAUSE;
        else if (lp) begin m_state = M_LAP; m_lap = pre; end
      end
      M_LAP: begin
        if (sat)     begin m_state = M_PAUSE; m_ovf = 1'b1; end
        else if (ss) m_state = M_PAUSE;
        else if (lp) m_state = M_RUN;
      end
      default: begin
        if (cl) begin m_state = M_IDLE; m_total = 0; m_lap = 0; m_ovf = 1'b0; end
        else if (ss && !m_ovf) m_state = M_RUN;
      end
    endcase
  endfunction

  function automatic logic [19:0] digits_of(int t);
    return {4'(t / 6000), 4'((t / 600) % 10), 4'((t / 100) % 6), 4'((t / 10) % 10), 4'(t % 10)};
  endfunction

  function automatic logic [W-1:0] model_exp();
    int disp;
    disp = (m_state == M_LAP) ? m_lap : m_total;
    return {digits_of(disp), (m_state == M_RUN) || (m_state == M_LAP), m_state == M_LAP,
            m_ovf, 2'(m_state)};
  endfunction

  function automatic logic [W-1:0] dut_obs();
    return {sw_if.d_min_tens, sw_if.d_min_ones, sw_if.d_sec_tens, sw_if.d_sec_ones,
            sw_if.d_tenths, sw_if.running, sw_if.frozen, sw_if.overflow, sw_if.state};
  endfunction

  // Driver: inputs applied at negedge, DUT and model advance on the posedge, outputs read at next negedge
  task automatic cycle(bit t, bit ss, bit lp, bit cl);
    sw_if.tick_in    = t;
    sw_if.start_stop = ss;
    sw_if.lap        = lp;
    sw_if.clear      = cl;
    @(posedge clk);
    model_step(t, ss, lp, cl);
    @(negedge clk);
    sw_if.start_stop = 1'b0;
    sw_if.lap        = 1'b0;
    sw_if.clear      = 1'b0;
  endtask

  task automatic do_ticks(int n);
    repeat (n) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic press(bit ss, bit lp, bit cl);
    cycle(sw_if.tick_in, ss, lp, cl);
  endtask

  task automatic run_to(int target);
    int guard = 0;
    while (m_total < target && guard < 40000) begin
      do_ticks(1);
      guard++;
    end
    n_vec++;
    if (m_total != target) begin
      n_err++;
      $display("FAIL run_to_budget: reached %0d tenths, required %0d", m_total, target);
    end
  endtask

  task automatic test_reset();
    logic [W-1:0] obs;
    sw_if.tick_in = 1'b0; sw_if.start_stop = 1'b0; sw_if.lap = 1'b0; sw_if.clear = 1'b0;
    rst = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    obs = dut_obs();
    n_vec++;
    if (obs !== '0) begin
      n_err++; $display("FAIL reset_values: got %h want %h", obs, {W{1'b0}});
    end
  endtask

  task automatic test_start_stop();
    logic [W-1:0] obs;
    press(1'b1, 1'b0, 1'b0);
    obs = dut_obs();
    n_vec++;
    if (obs !== {20'h00000, 3'b100, 2'd1}) begin
      n_err++; $display("FAIL start_latency: got %h want %h", obs, {20'h00000, 3'b100, 2'd1});
    end
    do_ticks(25);
    obs = dut_obs();
    n_vec++;
    if (obs !== {20'h00025, 3'b100, 2'd1}) begin
      n_err++; $display("FAIL count_25: got %h want %h", obs, {20'h00025, 3'b100, 2'd1});
    end
    press(1'b1, 1'b0, 1'b0);
    do_ticks(10);
    obs = dut_obs();
    n_vec++;
    if (obs !== {20'h00025, 3'b000, 2'd3}) begin
      n_err++; $display("FAIL pause_holds: got %h want %h", obs, {20'h00025, 3'b000, 2'd3});
    end
    press(1'b0, 1'b0, 1'b1);
    obs = dut_obs();
    n_vec++;
    if (obs !== {20'h00000, 3'b000, 2'd0}) begin
      n_err++; $display("FAIL clear_paused: got %h want %h", obs, {20'h00000, 3'b000, 2'd0});
    end
  endtask

  task automatic test_lap();
    logic [W-1:0] obs;
    press(1'b1, 1'b0, 1'b0);
    do_ticks(34);
    press(1'b0, 1'b1, 1'b0);
    obs = dut_obs();
    n_vec++;
    if (obs !== {20'h00034, 3'b110, 2'd2}) begin
      n_err++; $display("FAIL lap_enter: got %h want %h", obs, {20'h00034, 3'b110, 2'd2});
    end
    do_ticks(12);
    obs = dut_obs();
    n_vec++;
    if (obs !== {20'h00034, 3'b110, 2'd2}) begin
      n_err++; $display("FAIL lap_frozen: got %h want %h", obs, {20'h00034, 3'b110, 2'd2});
    end
    press(1'b0, 1'b1, 1'b0);
    obs = dut_obs();
    n_vec++;
    if (obs !== {20'h00046, 3'b100, 2'd1}) begin
      n_err++; $display("FAIL lap_release: got %h want %h", obs, {20'h00046, 3'b100, 2'd1});
    end
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_coincident();
    logic [W-1:0] obs;
    press(1'b1, 1'b0, 1'b0);
    do_ticks(5);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    obs = dut_obs();
    n_vec++;
    if (obs !== {20'h00006, 3'b000, 2'd3}) begin
      n_err++; $display("FAIL run_stop_tick: got %h want %h", obs, {20'h00006, 3'b000, 2'd3});
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    obs = dut_obs();
    n_vec++;
    if (obs !== {20'h00006, 3'b100, 2'd1}) begin
      n_err++; $display("FAIL pause_start_tick: got %h want %h", obs, {20'h00006, 3'b100, 2'd1});
    end
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b1);
    obs = dut_obs();
    n_vec++;
    if (obs !== {20'h00000, 3'b000, 2'd0}) begin
      n_err++; $display("FAIL clear_beats_start: got %h want %h", obs, {20'h00000, 3'b000, 2'd0});
    end
  endtask

  task automatic test_random();
    logic [W-1:0] obs, exp;
    for (int i = 0; i < 2000; i++) begin
      cycle(1'($urandom_range(0, 1)), $urandom_range(0, 11) == 0,
            $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0);
      exp_q.push_back(model_exp());
      obs = dut_obs();
      exp = exp_q.pop_front();
      n_vec++;
      if (obs !== exp) begin
        n_err++; $display("FAIL random_cycle_%0d: got %h want %h", i, obs, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] obs;
    sw_if.tick_in = 1'b0;
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    press(1'b1, 1'b0, 1'b0);
    do_ticks(73);
    obs = dut_obs();
    n_vec++;
    if (obs !== {20'h00073, 3'b100, 2'd1}) begin
      n_err++; $display("FAIL pre_reset_count: got %h want %h", obs, {20'h00073, 3'b100, 2'd1});
    end
    #2 rst = 1'b1;
    #1 obs = dut_obs();
    model_reset();
    n_vec++;
    if (obs !== '0) begin
      n_err++; $display("FAIL async_reset: got %h want %h", obs, {W{1'b0}});
    end
    @(negedge clk);
    rst = 1'b0;
    press(1'b1, 1'b0, 1'b0);
    repeat (3) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    obs = dut_obs();
    n_vec++;
    if (obs !== {20'h00000, 3'b100, 2'd1}) begin
      n_err++; $display("FAIL no_spurious_tick: got %h want %h", obs, {20'h00000, 3'b100, 2'd1});
    end
    do_ticks(1);
    obs = dut_obs();
    n_vec++;
    if (obs !== {20'h00001, 3'b100, 2'd1}) begin
      n_err++; $display("FAIL first_real_tick: got %h want %h", obs, {20'h00001, 3'b100, 2'd1});
    end
  endtask

  task automatic test_carry_saturate();
    logic [W-1:0] obs;
    run_to(99);
    do_ticks(1);
    obs = dut_obs();
    n_vec++;
    if (obs !== {20'h00100, 3'b100, 2'd1}) begin
      n_err++; $display("FAIL carry_sec: got %h want %h", obs, {20'h00100, 3'b100, 2'd1});
    end
    run_to(599);
    do_ticks(1);
    obs = dut_obs();
    n_vec++;
    if (obs !== {20'h01000, 3'b100, 2'd1}) begin
      n_err++; $display("FAIL carry_min: got %h want %h", obs, {20'h01000, 3'b100, 2'd1});
    end
    run_to(5999);
    do_ticks(1);
    obs = dut_obs();
    n_vec++;
    if (obs !== {20'h10000, 3'b100, 2'd1}) begin
      n_err++; $display("FAIL carry_ten_min: got %h want %h", obs, {20'h10000, 3'b100, 2'd1});
    end
    run_to(35998);
    do_ticks(1);
    obs = dut_obs();
    n_vec++;
    if (obs !== {20'h59599, 3'b100, 2'd1}) begin
      n_err++; $display("FAIL reach_max: got %h want %h", obs, {20'h59599, 3'b100, 2'd1});
    end
    do_ticks(1);
    obs = dut_obs();
    n_vec++;
    if (obs !== {20'h59599, 3'b001, 2'd3}) begin
      n_err++; $display("FAIL saturate: got %h want %h", obs, {20'h59599, 3'b001, 2'd3});
    end
    press(1'b1, 1'b0, 1'b0);
    do_ticks(3);
    obs = dut_obs();
    n_vec++;
    if (obs !== {20'h59599, 3'b001, 2'd3}) begin
      n_err++; $display("FAIL start_after_ovf: got %h want %h", obs, {20'h59599, 3'b001, 2'd3});
    end
    n_vec++;
    if (obs !== model_exp()) begin
      n_err++; $display("FAIL model_after_ovf: got %h want %h", obs, model_exp());
    end
    press(1'b0, 1'b0, 1'b1);
    obs = dut_obs();
    n_vec++;
    if (obs !== {20'h00000, 3'b000, 2'd0}) begin
      n_err++; $display("FAIL clear_ovf: got %h want %h", obs, {20'h00000, 3'b000, 2'd0});
    end
  endtask

  initial begin
    test_reset();
    test_start_stop();
    test_lap();
    test_coincident();
    test_random();
    test_reset_mid();
    test_carry_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/stopwatch_core.md
# stopwatch_core

Stopwatch time-keeping core that consumes the 10 Hz square wave from the tenth-second enable stage and debounced button pulses. It counts elapsed time as BCD digits (MM:SS.t, up to 59:59.9) under a start/stop/lap/clear state machine, and drives the display digits to the seven-segment multiplexer downstream.

## Interface
Parameters:
- TICK_EDGE_RISING, default 1: count on the rising edge of tick_in (1) or the falling edge (0).

Ports:
- clk  in  1  system clock (100 MHz).
- rst  in  1  reset, asynchronous, active-high.
- tick_in  in  1  10 Hz square wave, synchronous to clk; one selected edge = one tenth of a second.
- start_stop  in  1  single-cycle pulse: start or stop.
- lap  in  1  single-cycle pulse: freeze or release the display.
- clear  in  1  single-cycle pulse: zero the time while stopped.
- d_tenths  out  4  BCD tenths digit, 0–9.
- d_sec_ones  out  4  BCD, 0–9.
- d_sec_tens  out  4  BCD, 0–5.
- d_min_ones  out  4  BCD, 0–9.
- d_min_tens  out  4  BCD, 0–5.
- running  out  1  state is RUN or LAP.
- frozen  out  1  state is LAP; the display shows the lap snapshot.
- overflow  out  1  sticky; set on saturation at 59:59.9.

## Operation
- Edge detect: tick_q <= tick_in. tick_pulse = tick_in & ~tick_q for rising-edge mode, or ~tick_in & tick_q for falling-edge mode. tick_q resets to the idle level of the selected edge (1 for rising, 0 for falling), so no spurious count occurs after reset.
- Count chain: five BCD digits with moduli 10/10/6/10/6, ripple carry, all updated in the same clk edge. An increment happens when tick_pulse=1 and the current state is RUN or LAP.
- Saturation: a tick at 59:59.9 does not wrap. The count holds at 59:59.9, overflow is set to 1, and the state goes to PAUSE.
- Lap snapshot: the five digits are captured into lap registers on entry to LAP. The captured value is the count register value before any same-cycle increment.
- Display mux: frozen=1 selects the lap registers; otherwise the live count drives the outputs. The mux is combinational from registers.
- FSM states: IDLE, RUN, LAP, PAUSE. Transitions:
  - IDLE: start_stop -> RUN. lap and clear are no-ops.
  - RUN: start_stop -> PAUSE. lap -> LAP (snapshot taken). clear is ignored.
  - LAP: start_stop -> PAUSE (display returns to live). lap -> RUN. clear is ignored. Counting continues in LAP.
  - PAUSE: start_stop -> RUN, unless overflow=1, in which case it is ignored. clear -> IDLE, zeroes all digits and lap registers, and clears overflow. lap is ignored.
- Simultaneous pulses: priority is clear > start_stop > lap, applied only among pulses that are legal in the current state. Lower-priority pulses in the same cycle are dropped.
- Tick coincident with a transition: counting is decided by the current (pre-edge) state. Examples: RUN + start_stop + tick counts, then pauses. PAUSE + start_stop + tick does not count.

## Timing
- Reset values: all digits 0, lap registers 0, state IDLE, running=0, frozen=0, overflow=0.
- Count latency: tick_in is sampled at edge N with tick_q=0 (rising mode); the digits show the new value after edge N, one clk after the sampled edge.
- Button latency: running and frozen reflect the pulse after the clk edge that samples it.
- The tick period of 10,000,000 clk cycles is irrelevant to correctness. The block must work for any tick spacing of 2 or more clk cycles.
- Reset mid-count returns everything to reset values immediately (asynchronously).

## Structure
- Package stopwatch_pkg holds:
  - the state encoding (IDLE=2'd0, RUN=2'd1, LAP=2'd2, PAUSE=2'd3);
  - the digit moduli constants (10, 10, 6, 10, 6);
  - the saturation value 5,9,5,9,9.
- Sub-module bcd_digit (parameter MODULUS; ports clk, rst, inc, clr, q[3:0], carry) is instantiated five times with carry chained to the next digit's inc. Saturation detection lives in stopwatch_core.

## Test plan
- Reset, then start_stop, then 25 rising tick edges -> digits 00:02.5, running=1. A following start_stop gives running=0, and 10 further ticks leave the value at 00:02.5.
- Run to 00:09.9, then one tick -> 00:10.0. Run to 00:59.9, one tick -> 01:00.0. At 09:59.9, one tick -> 10:00.0.
- In RUN at 00:03.4, pulse lap -> frozen=1 and the display holds 00:03.4 while 12 more ticks occur. Then pulse lap -> display shows live 00:04.6, frozen=0.
- Preload to 59:59.8 with 2 ticks -> 59:59.9, overflow=1, state PAUSE. Then start_stop is ignored. clear -> 00:00.0, overflow=0, IDLE.
- In PAUSE, clear and start_stop in the same cycle -> IDLE with zero digits. In RUN, start_stop coincident with a tick -> value increments by 0.1, then running=0.
- Assert rst while running at 00:07.3 with tick_in high -> all outputs 0. After release with tick_in still high, no count occurs until the next genuine rising edge.
